// File: rtl/uvma_axi5_tracker_pkg.sv
// rtl/uvma_axi5_tracker_pkg.sv - error bit map and shared helpers for the AXI5 transaction tracker
package uvma_axi5_tracker_pkg;

    // Bit positions inside err_o
    localparam int AW_STABLE     = 0;
    localparam int W_STABLE      = 1;
    localparam int AR_STABLE     = 2;
    localparam int WLAST_EARLY   = 3;
    localparam int WLAST_MISSING = 4;
    localparam int W_NO_AW       = 5;
    localparam int B_ORPHAN      = 6;
    localparam int R_ORPHAN      = 7;
    localparam int OVERFLOW      = 8;
    localparam int ERR_W         = 9;

    // Saturating +1 for counters up to 64 bits; max is the all-ones value of the caller's width
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
        return (value == max) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/uvma_axi5_len_fifo.sv
// rtl/uvma_axi5_len_fifo.sv - 8-bit burst-length FIFO with empty-case bypass
// Ports: push/push_data write an entry, pop retires the head; head shows the
// oldest entry, or push_data when empty so a same-cycle push can be consumed.
// full/empty reflect current occupancy, empty_nxt the occupancy after this edge.
module uvma_axi5_len_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       empty_nxt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;
    logic          bypass;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = empty ? push_data : mem[rd_ptr];

    // Push and pop into an empty FIFO: the entry passes straight through
    assign bypass    = empty & push & pop;
    assign do_wr     = push & ~full & ~bypass;
    assign do_rd     = pop & ~empty;
    assign count_nxt = count + (PW+1)'(do_wr) - (PW+1)'(do_rd);
    assign empty_nxt = (count_nxt == '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/uvma_axi5_txn_tracker.sv
// rtl/uvma_axi5_txn_tracker.sv - passive AXI5 link checker: outstanding tracking, WLAST and stability checks
// Ports: AW/W/B/AR/R channel signals are observed only. clear_i wipes err_o and
// the handshake counters. err_o holds sticky flags, wr/rd_outstanding_o total
// bursts in flight, *_cnt_o saturating handshake counts, idle_o nothing pending.
module uvma_axi5_txn_tracker
    import uvma_axi5_tracker_pkg::*;
#(
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]                aw_len,
    input  logic                      aw_valid,
    input  logic                      aw_ready,
    input  logic                      w_last,
    input  logic                      w_valid,
    input  logic                      w_ready,
    input  logic [AXI_ID_WIDTH-1:0]   b_id,
    input  logic                      b_valid,
    input  logic                      b_ready,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]                ar_len,
    input  logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]   r_id,
    input  logic                      r_last,
    input  logic                      r_valid,
    input  logic                      r_ready,
    input  logic                      clear_i,
    output logic [ERR_W-1:0]          err_o,
    output logic [AXI_ID_WIDTH+$clog2(MAX_OUTSTANDING):0] wr_outstanding_o,
    output logic [AXI_ID_WIDTH+$clog2(MAX_OUTSTANDING):0] rd_outstanding_o,
    output logic [CNT_WIDTH-1:0]      aw_cnt_o,
    output logic [CNT_WIDTH-1:0]      ar_cnt_o,
    output logic [CNT_WIDTH-1:0]      b_cnt_o,
    output logic [CNT_WIDTH-1:0]      rlast_cnt_o,
    output logic                      idle_o
);

    localparam int NID = 2 ** AXI_ID_WIDTH;
    localparam int PW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int OW  = AXI_ID_WIDTH + PW;
    localparam logic [PW-1:0] CMAX    = PW'(MAX_OUTSTANDING);
    localparam logic [63:0]   CNT_MAX = 64'({CNT_WIDTH{1'b1}});

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rl_hs;
    logic [PW-1:0] wr_cnt [NID];
    logic [PW-1:0] rd_cnt [NID];
    logic [7:0]    beat;
    logic [7:0]    head_len;
    logic          fifo_push, fifo_full, fifo_empty, fifo_empty_nxt;
    logic          head_ok, w_use, w_end;
    logic          wr_same, rd_same;
    logic          wr_inc_ok, wr_dec_ok, rd_inc_ok, rd_dec_ok;
    logic [OW-1:0] wr_tot_nxt, rd_tot_nxt;
    logic [ERR_W-1:0] err_set;

    // Previous-edge snapshot for the VALID/payload stability checks
    logic                      aw_pend, w_pend, ar_pend;
    logic [AXI_ID_WIDTH-1:0]   aw_id_q, ar_id_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [7:0]                aw_len_q, ar_len_q;
    logic                      w_last_q;

    assign aw_hs = aw_valid & aw_ready;
    assign w_hs  = w_valid & w_ready;
    assign b_hs  = b_valid & b_ready;
    assign ar_hs = ar_valid & ar_ready;
    assign r_hs  = r_valid & r_ready;
    assign rl_hs = r_hs & r_last;

    assign fifo_push = aw_hs & ~fifo_full;
    // A W beat has a length to check against if one is queued or arriving now
    assign head_ok   = ~fifo_empty | fifo_push;
    assign w_use     = w_hs & head_ok;
    assign w_end     = w_use & (w_last | (beat == head_len));

    uvma_axi5_len_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_len_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (aw_len),
        .pop       (w_end),
        .head      (head_len),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt)
    );

    // Same-ID increment and decrement cancel and are exempt from limit checks
    assign wr_same   = aw_hs & b_hs & (aw_id == b_id);
    assign rd_same   = ar_hs & rl_hs & (ar_id == r_id);
    assign wr_inc_ok = aw_hs & ~wr_same & (wr_cnt[aw_id] != CMAX);
    assign wr_dec_ok = b_hs & ~wr_same & (wr_cnt[b_id] != '0);
    assign rd_inc_ok = ar_hs & ~rd_same & (rd_cnt[ar_id] != CMAX);
    assign rd_dec_ok = rl_hs & ~rd_same & (rd_cnt[r_id] != '0);

    assign wr_tot_nxt = wr_outstanding_o + OW'(wr_inc_ok) - OW'(wr_dec_ok);
    assign rd_tot_nxt = rd_outstanding_o + OW'(rd_inc_ok) - OW'(rd_dec_ok);

    always_comb begin
        err_set = '0;
        err_set[AW_STABLE]     = aw_pend & (~aw_valid | (aw_id != aw_id_q) |
                                 (aw_addr != aw_addr_q) | (aw_len != aw_len_q));
        err_set[W_STABLE]      = w_pend & (~w_valid | (w_last != w_last_q));
        err_set[AR_STABLE]     = ar_pend & (~ar_valid | (ar_id != ar_id_q) |
                                 (ar_addr != ar_addr_q) | (ar_len != ar_len_q));
        err_set[WLAST_EARLY]   = w_use & w_last & (beat < head_len);
        err_set[WLAST_MISSING] = w_use & ~w_last & (beat == head_len);
        err_set[W_NO_AW]       = w_hs & ~head_ok;
        err_set[B_ORPHAN]      = b_hs & ~wr_same & (wr_cnt[b_id] == '0);
        // Non-last R beats never decrement, so the same-ID exemption needs r_last
        err_set[R_ORPHAN]      = r_hs & ~rd_same & (rd_cnt[r_id] == '0);
        err_set[OVERFLOW]      = (aw_hs & fifo_full) |
                                 (aw_hs & ~wr_same & (wr_cnt[aw_id] == CMAX)) |
                                 (ar_hs & ~rd_same & (rd_cnt[ar_id] == CMAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NID; i++) begin
                wr_cnt[i] <= '0;
                rd_cnt[i] <= '0;
            end
            beat             <= '0;
            aw_pend          <= 1'b0;
            w_pend           <= 1'b0;
            ar_pend          <= 1'b0;
            aw_id_q          <= '0;
            ar_id_q          <= '0;
            aw_addr_q        <= '0;
            ar_addr_q        <= '0;
            aw_len_q         <= '0;
            ar_len_q         <= '0;
            w_last_q         <= 1'b0;
            err_o            <= '0;
            wr_outstanding_o <= '0;
            rd_outstanding_o <= '0;
            aw_cnt_o         <= '0;
            ar_cnt_o         <= '0;
            b_cnt_o          <= '0;
            rlast_cnt_o      <= '0;
            idle_o           <= 1'b1;
        end else begin
            // When both are enabled the IDs differ, so the two writes never collide
            if (wr_inc_ok) wr_cnt[aw_id] <= wr_cnt[aw_id] + PW'(1);
            if (wr_dec_ok) wr_cnt[b_id]  <= wr_cnt[b_id] - PW'(1);
            if (rd_inc_ok) rd_cnt[ar_id] <= rd_cnt[ar_id] + PW'(1);
            if (rd_dec_ok) rd_cnt[r_id]  <= rd_cnt[r_id] - PW'(1);

            if (w_use) beat <= w_end ? 8'd0 : beat + 8'd1;

            aw_pend   <= aw_valid & ~aw_ready;
            w_pend    <= w_valid & ~w_ready;
            ar_pend   <= ar_valid & ~ar_ready;
            aw_id_q   <= aw_id;
            ar_id_q   <= ar_id;
            aw_addr_q <= aw_addr;
            ar_addr_q <= ar_addr;
            aw_len_q  <= aw_len;
            ar_len_q  <= ar_len;
            w_last_q  <= w_last;

            wr_outstanding_o <= wr_tot_nxt;
            rd_outstanding_o <= rd_tot_nxt;
            idle_o <= (wr_tot_nxt == '0) && (rd_tot_nxt == '0) && fifo_empty_nxt;

            if (clear_i) begin
                err_o       <= '0;
                aw_cnt_o    <= '0;
                ar_cnt_o    <= '0;
                b_cnt_o     <= '0;
                rlast_cnt_o <= '0;
            end else begin
                err_o <= err_o | err_set;
                if (aw_hs) aw_cnt_o    <= CNT_WIDTH'(sat_inc(64'(aw_cnt_o), CNT_MAX));
                if (ar_hs) ar_cnt_o    <= CNT_WIDTH'(sat_inc(64'(ar_cnt_o), CNT_MAX));
                if (b_hs)  b_cnt_o     <= CNT_WIDTH'(sat_inc(64'(b_cnt_o), CNT_MAX));
                if (rl_hs) rlast_cnt_o <= CNT_WIDTH'(sat_inc(64'(rlast_cnt_o), CNT_MAX));
            end
        end
    end

endmodule

// File: tb/tb_uvma_axi5_txn_tracker.sv
// tb/tb_uvma_axi5_txn_tracker.sv - scoreboard bench for the AXI5 transaction tracker
module tb_uvma_axi5_txn_tracker;

    localparam int MAXO = 8;
    localparam longint CMAX32 = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear_i;
    logic [3:0]  aw_id, b_id, ar_id, r_id;
    logic [63:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic [8:0]  err_o;
    logic [7:0]  wr_outstanding_o, rd_outstanding_o;
    logic [31:0] aw_cnt_o, ar_cnt_o, b_cnt_o, rlast_cnt_o;
    logic        idle_o;

    uvma_axi5_txn_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .clear_i(clear_i), .err_o(err_o),
        .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o),
        .aw_cnt_o(aw_cnt_o), .ar_cnt_o(ar_cnt_o), .b_cnt_o(b_cnt_o), .rlast_cnt_o(rlast_cnt_o),
        .idle_o(idle_o)
    );

    typedef struct {
        logic rst_n, clr;
        logic [3:0] aw_id; logic [63:0] aw_addr; logic [7:0] aw_len; logic aw_valid, aw_ready;
        logic w_last, w_valid, w_ready;
        logic [3:0] b_id; logic b_valid, b_ready;
        logic [3:0] ar_id; logic [63:0] ar_addr; logic [7:0] ar_len; logic ar_valid, ar_ready;
        logic [3:0] r_id; logic r_last, r_valid, r_ready;
    } stim_t;

    typedef struct {
        logic [8:0] err; int wr; int rd; logic idle;
        longint awc, arc, bc, rlc;
    } exp_t;

    exp_t  expq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    stim_t s;

    // Reference model: bursts in flight per ID, queued AW lengths, current W beat index
    int      m_wr[16];
    int      m_rd[16];
    int      m_lenq[$];
    int      m_beat;
    logic [8:0] m_err;
    longint  m_awc, m_arc, m_bc, m_rlc;
    bit      m_awp, m_wp, m_arp;
    stim_t   m_prev;

    function automatic longint sat(longint v);
        return (v >= CMAX32) ? v : v + 1;
    endfunction

    task automatic clr_stim();
        s = '{default: '0};
        s.rst_n = 1'b1;
    endtask

    task automatic model_step();
        logic [8:0] e;
        bit awh, wh, bh, arh, rh, rsame;
        int tw, tr;
        exp_t x;
        if (!s.rst_n) begin
            foreach (m_wr[i]) begin m_wr[i] = 0; m_rd[i] = 0; end
            m_lenq.delete();
            m_beat = 0; m_err = '0;
            m_awc = 0; m_arc = 0; m_bc = 0; m_rlc = 0;
            m_awp = 0; m_wp = 0; m_arp = 0;
        end else begin
            e = '0;
            awh = s.aw_valid && s.aw_ready;
            wh  = s.w_valid && s.w_ready;
            bh  = s.b_valid && s.b_ready;
            arh = s.ar_valid && s.ar_ready;
            rh  = s.r_valid && s.r_ready;
            if (m_awp && (!s.aw_valid || s.aw_id != m_prev.aw_id || s.aw_addr != m_prev.aw_addr ||
                          s.aw_len != m_prev.aw_len)) e[0] = 1'b1;
            if (m_wp && (!s.w_valid || s.w_last != m_prev.w_last)) e[1] = 1'b1;
            if (m_arp && (!s.ar_valid || s.ar_id != m_prev.ar_id || s.ar_addr != m_prev.ar_addr ||
                          s.ar_len != m_prev.ar_len)) e[2] = 1'b1;
            // Queue the new length first so an empty queue is served by this AW
            if (awh) begin
                if (m_lenq.size() == MAXO) e[8] = 1'b1;
                else m_lenq.push_back(int'(s.aw_len));
            end
            if (wh) begin
                if (m_lenq.size() == 0) e[5] = 1'b1;
                else begin
                    if (s.w_last && m_beat < m_lenq[0]) e[3] = 1'b1;
                    if (!s.w_last && m_beat == m_lenq[0]) e[4] = 1'b1;
                    if (s.w_last || m_beat == m_lenq[0]) begin
                        void'(m_lenq.pop_front());
                        m_beat = 0;
                    end else m_beat++;
                end
            end
            if (!(awh && bh && s.aw_id == s.b_id)) begin
                if (awh) begin
                    if (m_wr[s.aw_id] == MAXO) e[8] = 1'b1; else m_wr[s.aw_id]++;
                end
                if (bh) begin
                    if (m_wr[s.b_id] == 0) e[6] = 1'b1; else m_wr[s.b_id]--;
                end
            end
            rsame = arh && rh && s.r_last && s.ar_id == s.r_id;
            if (rh && m_rd[s.r_id] == 0 && !rsame) e[7] = 1'b1;
            if (!rsame) begin
                if (arh) begin
                    if (m_rd[s.ar_id] == MAXO) e[8] = 1'b1; else m_rd[s.ar_id]++;
                end
                if (rh && s.r_last && m_rd[s.r_id] > 0) m_rd[s.r_id]--;
            end
            if (s.clr) begin
                m_err = '0; m_awc = 0; m_arc = 0; m_bc = 0; m_rlc = 0;
            end else begin
                m_err = m_err | e;
                if (awh) m_awc = sat(m_awc);
                if (arh) m_arc = sat(m_arc);
                if (bh)  m_bc  = sat(m_bc);
                if (rh && s.r_last) m_rlc = sat(m_rlc);
            end
            m_awp = s.aw_valid && !s.aw_ready;
            m_wp  = s.w_valid && !s.w_ready;
            m_arp = s.ar_valid && !s.ar_ready;
            m_prev = s;
        end
        tw = 0; tr = 0;
        foreach (m_wr[i]) begin tw += m_wr[i]; tr += m_rd[i]; end
        x.err = m_err; x.wr = tw; x.rd = tr;
        x.idle = (tw == 0 && tr == 0 && m_lenq.size() == 0);
        x.awc = m_awc; x.arc = m_arc; x.bc = m_bc; x.rlc = m_rlc;
        expq.push_back(x);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expected outcome
    task automatic step();
        @(negedge clk);
        rst_n = s.rst_n; clear_i = s.clr;
        aw_id = s.aw_id; aw_addr = s.aw_addr; aw_len = s.aw_len; aw_valid = s.aw_valid; aw_ready = s.aw_ready;
        w_last = s.w_last; w_valid = s.w_valid; w_ready = s.w_ready;
        b_id = s.b_id; b_valid = s.b_valid; b_ready = s.b_ready;
        ar_id = s.ar_id; ar_addr = s.ar_addr; ar_len = s.ar_len; ar_valid = s.ar_valid; ar_ready = s.ar_ready;
        r_id = s.r_id; r_last = s.r_last; r_valid = s.r_valid; r_ready = s.r_ready;
        model_step();
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every edge that follows a driven cycle presents a fresh set of outputs
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("err_o", 64'(err_o), 64'(x.err));
                chk("wr_outstanding", 64'(wr_outstanding_o), 64'(x.wr));
                chk("rd_outstanding", 64'(rd_outstanding_o), 64'(x.rd));
                chk("idle_o", 64'(idle_o), 64'(x.idle));
                chk("aw_cnt", 64'(aw_cnt_o), x.awc);
                chk("ar_cnt", 64'(ar_cnt_o), x.arc);
                chk("b_cnt", 64'(b_cnt_o), x.bc);
                chk("rlast_cnt", 64'(rlast_cnt_o), x.rlc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic gen_rand();
        bit awp, wp, arp;
        awp = s.rst_n && s.aw_valid && !s.aw_ready;
        wp  = s.rst_n && s.w_valid && !s.w_ready;
        arp = s.rst_n && s.ar_valid && !s.ar_ready;
        s.rst_n = ($urandom_range(0, 499) != 0);
        s.clr   = ($urandom_range(0, 24) == 0);
        if (awp && $urandom_range(0, 9) != 0) s.aw_valid = 1'b1;
        else begin
            s.aw_valid = ($urandom_range(0, 3) == 0);
            s.aw_id    = 4'($urandom_range(0, 3));
            s.aw_addr  = {$urandom, $urandom};
            s.aw_len   = 8'($urandom_range(0, 3));
        end
        s.aw_ready = ($urandom_range(0, 3) != 0);
        if (wp && $urandom_range(0, 9) != 0) s.w_valid = 1'b1;
        else begin
            s.w_valid = 1'($urandom_range(0, 1));
            if (m_lenq.size() > 0 && m_beat == m_lenq[0]) s.w_last = ($urandom_range(0, 9) != 0);
            else s.w_last = ($urandom_range(0, 9) == 0);
        end
        s.w_ready = ($urandom_range(0, 3) != 0);
        s.b_valid = ($urandom_range(0, 3) == 0);
        s.b_id    = 4'($urandom_range(0, 3));
        s.b_ready = 1'($urandom_range(0, 1));
        if (arp && $urandom_range(0, 9) != 0) s.ar_valid = 1'b1;
        else begin
            s.ar_valid = ($urandom_range(0, 3) == 0);
            s.ar_id    = 4'($urandom_range(0, 3));
            s.ar_addr  = {$urandom, $urandom};
            s.ar_len   = 8'($urandom_range(0, 3));
        end
        s.ar_ready = ($urandom_range(0, 3) != 0);
        s.r_valid  = ($urandom_range(0, 2) == 0);
        s.r_id     = 4'($urandom_range(0, 3));
        s.r_last   = 1'($urandom_range(0, 1));
        s.r_ready  = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        clr_stim();
        s.rst_n = 1'b0;
        rst_n = 1'b0; clear_i = 1'b0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0; aw_ready = 1'b0;
        w_last = 1'b0; w_valid = 1'b0; w_ready = 1'b0;
        b_id = '0; b_valid = 1'b0; b_ready = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0; ar_ready = 1'b0;
        r_id = '0; r_last = 1'b0; r_valid = 1'b0; r_ready = 1'b0;

        step(); step();
        clr_stim(); step();

        // Clean write burst: AW id3 len3, four beats, B id3
        s.aw_valid = 1; s.aw_ready = 1; s.aw_id = 3; s.aw_len = 3; step();
        for (int i = 0; i < 4; i++) begin
            clr_stim(); s.w_valid = 1; s.w_ready = 1; s.w_last = (i == 3); step();
        end
        clr_stim(); s.b_valid = 1; s.b_ready = 1; s.b_id = 3; step();
        clr_stim(); step();

        // Early WLAST, then a clean single-beat burst
        s.aw_valid = 1; s.aw_ready = 1; s.aw_id = 0; s.aw_len = 3; step();
        clr_stim(); s.w_valid = 1; s.w_ready = 1; step();
        s.w_last = 1; step();
        clr_stim(); s.aw_valid = 1; s.aw_ready = 1; s.aw_id = 0; s.aw_len = 0; step();
        clr_stim(); s.w_valid = 1; s.w_ready = 1; s.w_last = 1; step();
        clr_stim(); s.b_valid = 1; s.b_ready = 1; s.b_id = 0; step(); step();
        clr_stim(); s.clr = 1; step();

        // Orphan B, then clear
        clr_stim(); s.b_valid = 1; s.b_ready = 1; s.b_id = 5; step();
        clr_stim(); step();
        s.clr = 1; step();
        clr_stim(); step();

        // AR address changes while stalled
        s.ar_valid = 1; s.ar_addr = 64'h1000; step();
        s.ar_addr = 64'h2000; step();
        s.ar_ready = 1; step();
        clr_stim(); s.r_valid = 1; s.r_ready = 1; s.r_last = 1; s.r_id = 0; step();
        clr_stim(); s.clr = 1; step();

        // Nine reads on id1 with a limit of eight, then drain
        for (int i = 0; i < 9; i++) begin
            clr_stim(); s.ar_valid = 1; s.ar_ready = 1; s.ar_id = 1; step();
        end
        for (int i = 0; i < 8; i++) begin
            clr_stim(); s.r_valid = 1; s.r_ready = 1; s.r_last = 1; s.r_id = 1; step();
        end
        clr_stim(); s.clr = 1; step();

        // Same-cycle AR and R-last on id2, then reset in the middle of a write burst
        clr_stim(); s.ar_valid = 1; s.ar_ready = 1; s.ar_id = 2; step();
        s.r_valid = 1; s.r_ready = 1; s.r_last = 1; s.r_id = 2; step();
        clr_stim(); s.aw_valid = 1; s.aw_ready = 1; s.aw_id = 4; s.aw_len = 2; step();
        clr_stim(); s.w_valid = 1; s.w_ready = 1; step();
        clr_stim(); s.rst_n = 0; step(); step();
        clr_stim(); step();

        for (int i = 0; i < 1500; i++) begin
            gen_rand();
            step();
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
